// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single-outstanding imem handshake
//
// Owns the program counter, issues one instruction-memory request at a time,
// and presents each fetched word (tagged with its address) to decode under a
// valid/ready handshake. Redirects (taken branch, jal, jalr) replace the pc
// and any fetch already in flight for the old path is discarded.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   imem_req       out  1   fetch request outstanding (registered)
//   imem_addr      out  32  fetch byte address, word aligned (registered)
//   imem_rvalid    in   1   one-cycle response strobe
//   imem_rdata     in   32  instruction word, valid with imem_rvalid
//   if_valid       out  1   if_instr/if_pc valid for decode (registered)
//   if_instr       out  32  instruction presented to decode
//   if_pc          out  32  address of if_instr
//   id_ready       in   1   decode accepts this cycle
//   redirect_valid in   1   redirect pulse
//   redirect_pc    in   32  redirect target, low two bits ignored

module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // IDLE : no request, one dead cycle before the next fetch goes out
    // FETCH: request outstanding on the current path
    // HOLD : instruction held for decode, memory quiet
    // DROP : request outstanding on a path already abandoned by a redirect
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        req_d;
    logic [31:0] addr_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] ifpc_d;
    logic [31:0] redirect_tgt;

    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign redirect_tgt = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC_A;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC_A;
            if_valid  <= 1'b0;
            if_instr  <= NOP_INSTR;
            if_pc     <= RESET_PC_A;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            if_valid  <= valid_d;
            if_instr  <= instr_d;
            if_pc     <= ifpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        valid_d = if_valid;
        instr_d = if_instr;
        ifpc_d  = if_pc;

        unique case (state_q)
            IDLE: begin
                // A late rvalid here belongs to nothing and is ignored.
                state_d = FETCH;
                req_d   = 1'b1;
                if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    addr_d = redirect_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end

            FETCH: begin
                if (redirect_valid && imem_rvalid) begin
                    // Response arrives for the old path; nothing left in flight.
                    pc_d    = redirect_tgt;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (redirect_valid) begin
                    // Address must stay stable until the response, so the
                    // old request completes in DROP and is thrown away.
                    pc_d    = redirect_tgt;
                    state_d = DROP;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    ifpc_d  = imem_addr;
                    valid_d = 1'b1;
                    pc_d    = imem_addr + 32'd4;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // Redirect wins over id_ready: the held word is never handed over.
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_tgt;
                    req_d   = 1'b1;
                    addr_d  = redirect_tgt;
                    state_d = FETCH;
                end else if (id_ready) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end

            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        mem_rvalid = 1'b0;
    logic        extra_rvalid = 1'b0;
    int          lat = 1;
    int          mem_cnt = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    logic [63:0] exp_q[$];
    logic [31:0] req_log[$];

    logic        prev_req = 1'b0;
    logic        prev_rv = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_ipc = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    assign imem_rvalid = mem_rvalid | extra_rvalid;
    assign imem_rdata  = imem_rvalid ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int n);
        int k;
        k = 0;
        while (n_xfer < n && k < 300) begin
            step();
            k++;
        end
        check("wait_xfer", 32'(n_xfer >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!if_valid && k < 300) begin
            step();
            k++;
        end
        check("wait_valid", 32'(if_valid), 32'd1);
    endtask

    task automatic wait_req_low();
        int k;
        k = 0;
        while (imem_req && k < 300) begin
            step();
            k++;
        end
        check("wait_req_low", 32'(imem_req), 32'd0);
    endtask

    // Memory: responds once a request has been high for more than lat cycles.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_rvalid = 1'b0;
            mem_cnt    = 0;
        end else if (mem_rvalid) begin
            mem_rvalid = 1'b0;
            mem_cnt    = 0;
        end else if (imem_req) begin
            mem_cnt++;
            if (mem_cnt > lat) mem_rvalid = 1'b1;
        end else begin
            mem_cnt = 0;
        end
    end

    // Monitor: protocol checks and scoreboard pop on every decode transfer.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (imem_req && prev_req) begin
                check("req_gap_after_rvalid", 32'(prev_rv), 32'd0);
                if (!prev_rv) check("addr_stable", imem_addr, prev_addr);
            end
            if (imem_req && !prev_req) req_log.push_back(imem_addr);
            if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (if_valid && prev_valid) begin
                check("hold_pc_stable", if_pc, prev_ipc);
                check("hold_instr_stable", if_instr, prev_instr);
            end
            if (if_valid && id_ready && !redirect_valid) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got pc %h instr %h expected none", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", if_pc, e[63:32]);
                    check("xfer_instr", if_instr, e[31:0]);
                end
            end
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_rv    = imem_rvalid & imem_req;
            prev_valid = if_valid;
            prev_ipc   = if_pc;
            prev_instr = if_instr;
        end else begin
            prev_req   = 1'b0;
            prev_rv    = 1'b0;
            prev_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        step();
        step();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_if_pc", if_pc, 32'h0);

        // Sequential fetch 0x0, 0x4 with 1-cycle memory
        rst_n    = 1'b1;
        id_ready = 1'b1;
        exp_q.push_back({32'h0, 32'h0000_0093});
        exp_q.push_back({32'h4, 32'h0004_0093});
        wait_xfer(1);

        // Decode stall with 0x4 held
        id_ready = 1'b0;
        wait_valid();
        check("stall_pc", if_pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc_hold", if_pc, 32'h4);
            check("stall_instr_hold", if_instr, 32'h0004_0093);
            check("stall_req_low", 32'(imem_req), 32'd0);
        end
        lat      = 3;
        id_ready = 1'b1;
        wait_xfer(2);

        // Redirect to 0x100 while fetch at 0x8 outstanding
        check("fetch8_addr", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr_held", imem_addr, 32'h8);
        wait_req_low();
        lat = 1;
        check("log_len", 32'(req_log.size()), 32'd3);
        check("log_0", req_log[0], 32'h0);
        check("log_1", req_log[1], 32'h4);
        check("log_2", req_log[2], 32'h8);
        exp_q.push_back({32'h100, 32'h0100_0093});
        step();
        check("redir100_req", 32'(imem_req), 32'd1);
        check("redir100_addr", imem_addr, 32'h100);
        wait_xfer(3);

        // Redirect in HOLD with id_ready=1: no transfer
        wait_valid();
        check("hold104_pc", if_pc, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        check("hold_redir_no_xfer", 32'(n_xfer), 32'd3);
        check("hold_redir_valid", 32'(if_valid), 32'd0);
        check("hold_redir_req", 32'(imem_req), 32'd1);
        check("hold_redir_addr", imem_addr, 32'h200);
        exp_q.push_back({32'h200, 32'h0200_0093});
        wait_xfer(4);

        // Redirect coincident with rvalid in FETCH (0x204)
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("coinc_idle_req", 32'(imem_req), 32'd0);
        check("coinc_idle_valid", 32'(if_valid), 32'd0);
        step();
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h300);
        // Redirect to 0x400 -> DROP, then 0x500 together with rvalid
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        check("drop2_req", 32'(imem_req), 32'd1);
        check("drop2_addr", imem_addr, 32'h300);
        redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        check("drop2_idle_req", 32'(imem_req), 32'd0);
        exp_q.push_back({32'h500, 32'h0500_0093});
        step();
        check("final_target_addr", imem_addr, 32'h500);
        wait_xfer(5);

        // Asynchronous reset mid-FETCH at 0x504
        check("pre_rst_req", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_addr", imem_addr, 32'h0);
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_instr", if_instr, 32'h0000_0013);
        check("async_rst_pc", if_pc, 32'h0);
        step();
        step();
        rst_n          = 1'b1;
        extra_rvalid   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        extra_rvalid   = 1'b0;
        redirect_valid = 1'b0;
        check("late_rvalid_valid", 32'(if_valid), 32'd0);
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFC_0093});
        exp_q.push_back({32'h0, 32'h0000_0093});
        wait_xfer(6);
        check("wrap_next_addr", imem_addr, 32'h0);
        wait_xfer(7);
        id_ready = 1'b0;
        step();
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
